// File: rtl/mem_arbiter_ctrl_if.sv
// Request/response bundle between requesters and the shared data memory arbiter.
// Per-port fields are packed side by side: port p occupies [p*N +: N].
interface mem_arbiter_ctrl_if #(
  parameter int N         = 32,
  parameter int NUM_PORTS = 3
);
  // Handshake: a requester raises req[p] with wr_en/addr/wdata stable and holds
  // req[p] until valid[p] pulses for one cycle. Fields are sampled only at the
  // grant edge. err[p] and rdata are meaningful in the valid[p] cycle, and rdata
  // stays held until that port's next read completes.
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   wr_en;
  logic [NUM_PORTS*N-1:0] addr;
  logic [NUM_PORTS*N-1:0] wdata;
  logic [NUM_PORTS*N-1:0] rdata;
  logic [NUM_PORTS-1:0]   valid;
  logic [NUM_PORTS-1:0]   err;
  logic                   busy;

  modport master (
    output req, wr_en, addr, wdata,
    input  rdata, valid, err, busy
  );

  modport slave (
    input  req, wr_en, addr, wdata,
    output rdata, valid, err, busy
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Shared word-addressed data memory with a round-robin arbiter over NUM_PORTS requesters.
// Optional macro ARB_CPU_PRIO_EN: port 0 wins outright whenever it requests.
module mem_arbiter_ctrl #(
  parameter int N          = 32,
  parameter int NUM_PORTS  = 3,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  mem_arbiter_ctrl_if.slave   bus,
  output logic [1:0]          state_o
);

  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [PW-1:0] port_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  port_t                  last_grant_q, last_grant_d;
  port_t                  grant_q, grant_d;
  logic                   wr_q, wr_d;
  logic [N-1:0]           addr_q, addr_d;
  logic [N-1:0]           wdata_q, wdata_d;
  logic [NUM_PORTS*N-1:0] rdata_q, rdata_d;

  logic [N-1:0]           mem [DEPTH];

  port_t                  winner;
  port_t                  cand_p;
  logic                   found;
  logic                   any_req;
  logic [DEPTH_LOG2-1:0]  word_idx;
  logic                   out_of_range;
  logic                   unused_addr_lsb;

  // Everything below works off the latched request, never the live inputs.
  assign word_idx        = addr_q[DEPTH_LOG2+1:2];
  assign out_of_range    = |addr_q[N-1:DEPTH_LOG2+2];
  assign unused_addr_lsb = ^addr_q[1:0];
  assign any_req         = |bus.req;

  // Winner search starts one past the last grant and wraps.
  always_comb begin
    winner = '0;
    cand_p = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_p = port_t'((int'(last_grant_q) + i) % NUM_PORTS);
      if (!found && bus.req[cand_p]) begin
        winner = cand_p;
        found  = 1'b1;
      end
    end
`ifdef ARB_CPU_PRIO_EN
    if (bus.req[0]) begin
      winner = '0;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= port_t'(NUM_PORTS - 1);
      grant_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Array write; gating on rst keeps an aborted write from landing.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_ACCESS && wr_q && !out_of_range) begin
      mem[word_idx] <= wdata_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACCESS;
          grant_d = winner;
          wr_d    = bus.wr_en[winner];
          addr_d  = bus.addr[winner*N +: N];
          wdata_d = bus.wdata[winner*N +: N];
`ifdef ARB_CPU_PRIO_EN
          // Port 0 grants leave the rotation of the other ports untouched.
          if (winner != '0) begin
            last_grant_d = winner;
          end
`else
          last_grant_d = winner;
`endif
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!wr_q) begin
          rdata_d[grant_q*N +: N] = out_of_range ? '0 : mem[word_idx];
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.valid = '0;
    bus.err   = '0;
    bus.busy  = (state_q != S_IDLE);
    if (state_q == S_RESP) begin
      bus.valid[grant_q] = 1'b1;
      bus.err[grant_q]   = out_of_range;
    end
  end

  assign bus.rdata = rdata_q;
  assign state_o   = state_q;

  a_valid_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.valid));
  a_valid_spaced:  assert property (@(posedge clk) disable iff (rst)
                                    (bus.valid != '0) |=> (bus.valid == '0));

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl: write/read, round-robin order, RAW ordering,
// out-of-range handling, mid-operation reset, and CPU priority or fairness.
module tb_mem_arbiter_ctrl;

  localparam int N  = 32;
  localparam int NP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;

  // Recorded completions: port, cycle index (request cycle = 1), err at valid.
  int   ev_port [16];
  int   ev_cyc  [16];
  logic ev_err  [16];
  int   ev_n;

  logic [NP-1:0] prev_valid;

  mem_arbiter_ctrl_if #(.N(N), .NUM_PORTS(NP)) bus ();

  mem_arbiter_ctrl #(.N(N), .NUM_PORTS(NP), .DEPTH_LOG2(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Invariant: at most one valid per cycle, never two valid cycles in a row.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_valid = '0;
    end else begin
      vectors++;
      if ($countones(bus.valid) > 1 || (bus.valid != '0 && prev_valid != '0)) begin
        miscompares++;
        $display("FAIL valid_invariant: valid=%b prev=%b required onehot0 and not back-to-back",
                 bus.valid, prev_valid);
      end
      prev_valid = bus.valid;
    end
  end

  // Driver tasks
  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [N-1:0] a, input logic [N-1:0] d);
    bus.req[p]           = r;
    bus.wr_en[p]         = w;
    bus.addr[p*N +: N]   = a;
    bus.wdata[p*N +: N]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Watches up to max_cyc cycles for n_ev completions; drops req of ports in drop_mask when served.
  task automatic collect(input int n_ev, input logic [NP-1:0] drop_mask, input int max_cyc);
    ev_n = 0;
    for (int k = 0; k < 16; k++) begin
      ev_port[k] = -1;
      ev_cyc[k]  = -1;
      ev_err[k]  = 1'bx;
    end
    for (int c = 2; c <= max_cyc && ev_n < n_ev; c++) begin
      @(negedge clk);
      if (bus.valid != '0) begin
        for (int p = 0; p < NP; p++) begin
          if (bus.valid[p]) begin
            ev_port[ev_n] = p;
            ev_cyc[ev_n]  = c;
            ev_err[ev_n]  = bus.err[p];
            if (drop_mask[p]) bus.req[p] = 1'b0;
          end
        end
        ev_n++;
      end
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.wr_en = '0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rst_state: got %0d required 0", state); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    vectors++; if (bus.valid !== 3'b000) begin miscompares++; $display("FAIL rst_valid: got %b required 000", bus.valid); end
    vectors++; if (bus.err !== 3'b000) begin miscompares++; $display("FAIL rst_err: got %b required 000", bus.err); end
    vectors++; if (bus.rdata !== 96'h0) begin miscompares++; $display("FAIL rst_rdata: got %h required 0", bus.rdata); end
  endtask

  task automatic test_write_read();
    set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    collect(1, 3'b111, 20);
    vectors++; if (ev_n !== 1) begin miscompares++; $display("FAIL wr_count: got %0d required 1", ev_n); end
    vectors++; if (ev_port[0] !== 0) begin miscompares++; $display("FAIL wr_port: got %0d required 0", ev_port[0]); end
    vectors++; if (ev_cyc[0] !== 3) begin miscompares++; $display("FAIL wr_latency: got %0d required 3", ev_cyc[0]); end
    vectors++; if (ev_err[0] !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b required 0", ev_err[0]); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL wr_idle_busy: got %b required 0", bus.busy); end
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    collect(1, 3'b111, 20);
    vectors++; if (ev_cyc[0] !== 3) begin miscompares++; $display("FAIL rd_latency: got %0d required 3", ev_cyc[0]); end
    vectors++; if (ev_err[0] !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b required 0", ev_err[0]); end
    vectors++; if (bus.rdata[0 +: N] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data: got %h required deadbeef", bus.rdata[0 +: N]); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h14, 32'h0);
    set_port(2, 1'b1, 1'b0, 32'h10, 32'h0);
    collect(3, 3'b111, 30);
    vectors++; if (ev_n !== 3) begin miscompares++; $display("FAIL rr_count: got %0d required 3", ev_n); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (ev_port[k] !== k) begin miscompares++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, ev_port[k], k); end
      vectors++; if (ev_cyc[k] !== 3*(k+1)) begin miscompares++; $display("FAIL rr_cycle[%0d]: got %0d required %0d", k, ev_cyc[k], 3*(k+1)); end
    end
    vectors++; if (bus.rdata[0 +: N] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rr_rdata0: got %h required deadbeef", bus.rdata[0 +: N]); end
    vectors++; if (bus.rdata[2*N +: N] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rr_rdata2: got %h required deadbeef", bus.rdata[2*N +: N]); end
    @(negedge clk);
  endtask

  task automatic test_raw();
    set_port(1, 1'b1, 1'b1, 32'h40, 32'h5A5A5A5A);
    set_port(2, 1'b1, 1'b0, 32'h40, 32'h0);
    collect(2, 3'b111, 20);
    vectors++; if (ev_port[0] !== 1) begin miscompares++; $display("FAIL raw_first: got %0d required 1", ev_port[0]); end
    vectors++; if (ev_port[1] !== 2) begin miscompares++; $display("FAIL raw_second: got %0d required 2", ev_port[1]); end
    vectors++; if (ev_cyc[1] !== 6) begin miscompares++; $display("FAIL raw_cycle: got %0d required 6", ev_cyc[1]); end
    vectors++; if (bus.rdata[2*N +: N] !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL raw_data: got %h required 5a5a5a5a", bus.rdata[2*N +: N]); end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    set_port(0, 1'b1, 1'b1, 32'h0, 32'hCAFEF00D);
    collect(1, 3'b111, 20);
    @(negedge clk);
    set_port(0, 1'b1, 1'b1, 32'h00001000, 32'h12345678);
    collect(1, 3'b111, 20);
    vectors++; if (ev_port[0] !== 0) begin miscompares++; $display("FAIL oor_wr_port: got %0d required 0", ev_port[0]); end
    vectors++; if (ev_err[0] !== 1'b1) begin miscompares++; $display("FAIL oor_wr_err: got %b required 1", ev_err[0]); end
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 32'h0, 32'h0);
    collect(1, 3'b111, 20);
    vectors++; if (bus.rdata[0 +: N] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL oor_no_write: got %h required cafef00d", bus.rdata[0 +: N]); end
    vectors++; if (ev_err[0] !== 1'b0) begin miscompares++; $display("FAIL oor_inrange_err: got %b required 0", ev_err[0]); end
    @(negedge clk);
    set_port(1, 1'b1, 1'b0, 32'h00002000, 32'h0);
    collect(1, 3'b111, 20);
    vectors++; if (ev_err[0] !== 1'b1) begin miscompares++; $display("FAIL oor_rd_err: got %b required 1", ev_err[0]); end
    vectors++; if (bus.rdata[N +: N] !== 32'h0) begin miscompares++; $display("FAIL oor_rd_data: got %h required 0", bus.rdata[N +: N]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_port(1, 1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL mid_access_state: got %0d required 1", state); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_access_busy: got %b required 1", bus.busy); end
    rst = 1'b1;
    bus.req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b required 0", bus.busy); end
    vectors++; if (bus.valid !== 3'b000) begin miscompares++; $display("FAIL mid_valid: got %b required 000", bus.valid); end
    vectors++; if (bus.rdata[N +: N] !== 32'h0) begin miscompares++; $display("FAIL mid_rdata1: got %h required 0", bus.rdata[N +: N]); end
    set_port(0, 1'b1, 1'b0, 32'h40, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h40, 32'h0);
    set_port(2, 1'b1, 1'b0, 32'h40, 32'h0);
    collect(3, 3'b111, 30);
    vectors++; if (ev_port[0] !== 0) begin miscompares++; $display("FAIL mid_next_grant: got %0d required 0", ev_port[0]); end
    vectors++; if (ev_cyc[0] !== 3) begin miscompares++; $display("FAIL mid_next_cycle: got %0d required 3", ev_cyc[0]); end
    vectors++; if (bus.rdata[N +: N] !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL mid_reissue_data: got %h required 5a5a5a5a", bus.rdata[N +: N]); end
    @(negedge clk);
  endtask

`ifdef ARB_CPU_PRIO_EN
  task automatic test_cpu_prio();
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h40, 32'h0);
    collect(4, 3'b000, 30);
    vectors++; if (ev_n !== 4) begin miscompares++; $display("FAIL prio_count: got %0d required 4", ev_n); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (ev_port[k] !== 0) begin miscompares++; $display("FAIL prio_port[%0d]: got %0d required 0", k, ev_port[k]); end
    end
    bus.req[0] = 1'b0;
    @(negedge clk);
    collect(1, 3'b010, 20);
    vectors++; if (ev_port[0] !== 1) begin miscompares++; $display("FAIL prio_release: got %0d required 1", ev_port[0]); end
    vectors++; if (ev_cyc[0] !== 3) begin miscompares++; $display("FAIL prio_release_cycle: got %0d required 3", ev_cyc[0]); end
    @(negedge clk);
  endtask
`else
  task automatic test_fairness();
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b1, 1'b0, 32'h40, 32'h0);
    collect(4, 3'b000, 30);
    vectors++; if (ev_n !== 4) begin miscompares++; $display("FAIL fair_count: got %0d required 4", ev_n); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (ev_port[k] !== (k % 2)) begin miscompares++; $display("FAIL fair_port[%0d]: got %0d required %0d", k, ev_port[k], k % 2); end
      vectors++; if (ev_cyc[k] !== 3*(k+1)) begin miscompares++; $display("FAIL fair_cycle[%0d]: got %0d required %0d", k, ev_cyc[k], 3*(k+1)); end
    end
    bus.req = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_raw();
    test_out_of_range();
    test_reset_mid();
`ifdef ARB_CPU_PRIO_EN
    test_cpu_prio();
`else
    test_fairness();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
